// File: rtl/spike_pkg.sv
// Shared definitions for the sorter back-end: FSM states and the default sorter width.
package spike_pkg;

    typedef enum logic {
        S_INTEGRATE = 1'b0,
        S_REFRACT   = 1'b1
    } state_t;

    localparam int SORT_N = 16;
    localparam int CNT_W  = $clog2(SORT_N) + 1;

endpackage

// File: rtl/spike_integrate_fire_therm_to_count.sv
// Converts a sorted thermometer vector to an active-input count and flags
// any bubble (a one sitting directly below a zero).
module therm_to_count
    import spike_pkg::*;
#(
    parameter int N = SORT_N
) (
    input  logic [N-1:0]       sorted_in,
    output logic [$clog2(N):0] count,
    output logic               bubble
);

    localparam int CW = $clog2(N) + 1;

    // Popcount over every input bit.
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + {{(CW-1){1'b0}}, sorted_in[i]};
        end
    end

    // Scan adjacent pairs for a 0 above a 1.
    always_comb begin
        bubble = 1'b0;
        for (int i = 1; i < N; i++) begin
            if (!sorted_in[i] && sorted_in[i-1]) begin
                bubble = 1'b1;
            end else begin
                bubble = bubble;
            end
        end
    end

endmodule

// File: rtl/spike_integrate_fire.sv
// Integrate-and-fire stage: accumulates sorter counts minus a leak into a
// saturating potential, spikes at threshold, then blocks input while refractory.
module spike_integrate_fire
    import spike_pkg::*;
#(
    parameter int N       = 16,
    parameter int ACC_W   = 8,
    parameter int REFRACT = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          sorted_in,
    input  logic [ACC_W-1:0]      threshold,
    input  logic [ACC_W-1:0]      leak,
    output logic                  spike_out,
    output logic [ACC_W-1:0]      potential,
    output logic [$clog2(N):0]    count_out,
    output logic                  therm_err,
    output logic [15:0]           spike_count
);

    localparam int CW    = $clog2(N) + 1;
    localparam int SUM_W = (ACC_W + 1 > CW) ? ACC_W + 1 : CW + 1;
    localparam logic [ACC_W-1:0] POT_MAX   = {ACC_W{1'b1}};
    localparam logic [3:0]       REFR_LOAD = (REFRACT > 0) ? 4'(REFRACT - 1) : 4'd0;

    state_t             state_r;
    logic [3:0]         refr_cnt_r;
    logic [CW-1:0]      count_s;
    logic               bubble_s;
    logic               accept_s;
    logic [SUM_W-1:0]   sum_s;
    logic [ACC_W-1:0]   next_s;
    logic               fire_s;

    therm_to_count #(.N(N)) u_therm_to_count (
        .sorted_in (sorted_in),
        .count     (count_s),
        .bubble    (bubble_s)
    );

    assign in_ready = (state_r == S_INTEGRATE);
    assign accept_s = in_valid && in_ready;

    // Leak is floored at zero before the result is clamped to full scale.
    always_comb begin
        sum_s = SUM_W'(potential) + SUM_W'(count_s);
        if (sum_s < SUM_W'(leak)) begin
            next_s = '0;
        end else if ((sum_s - SUM_W'(leak)) > SUM_W'(POT_MAX)) begin
            next_s = POT_MAX;
        end else begin
            next_s = ACC_W'(sum_s - SUM_W'(leak));
        end
        fire_s = (next_s >= threshold);
    end

    // Handshake FSM, refractory timer and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_INTEGRATE;
            refr_cnt_r  <= 4'd0;
            potential   <= '0;
            count_out   <= '0;
            spike_out   <= 1'b0;
            therm_err   <= 1'b0;
            spike_count <= 16'd0;
        end else begin
            spike_out <= 1'b0;
            case (state_r)
                S_INTEGRATE: begin
                    if (accept_s) begin
                        count_out <= count_s;
                        therm_err <= bubble_s;
                        if (fire_s) begin
                            potential   <= '0;
                            spike_out   <= 1'b1;
                            spike_count <= spike_count + 16'd1;
                            if (REFRACT > 0) begin
                                state_r    <= S_REFRACT;
                                refr_cnt_r <= REFR_LOAD;
                            end else begin
                                state_r <= S_INTEGRATE;
                            end
                        end else begin
                            potential <= next_s;
                        end
                    end else begin
                        potential <= potential;
                    end
                end
                S_REFRACT: begin
                    if (refr_cnt_r == 4'd0) begin
                        state_r <= S_INTEGRATE;
                    end else begin
                        refr_cnt_r <= refr_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r    <= S_INTEGRATE;
                    refr_cnt_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_integrate_fire.sv
// Self-checking bench for spike_integrate_fire: directed scenarios plus random
// traffic against an arithmetic reference model of integrate-and-fire behaviour.
module tb_spike_integrate_fire;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [15:0] sorted_in;
    logic [7:0]  threshold;
    logic [7:0]  leak;

    logic rdy2, spk2, err2; logic [7:0] pot2; logic [4:0] cnt2; logic [15:0] sc2;
    logic rdy3, spk3, err3; logic [7:0] pot3; logic [4:0] cnt3; logic [15:0] sc3;
    logic rdy0, spk0, err0; logic [7:0] pot0; logic [4:0] cnt0; logic [15:0] sc0;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model state
    int   m_pot, m_refr, m_cnt, m_sc;
    logic m_err, m_spk;

    always #5 clk = ~clk;

    spike_integrate_fire #(.N(16), .ACC_W(8), .REFRACT(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy2),
        .sorted_in(sorted_in), .threshold(threshold), .leak(leak),
        .spike_out(spk2), .potential(pot2), .count_out(cnt2),
        .therm_err(err2), .spike_count(sc2));

    spike_integrate_fire #(.N(16), .ACC_W(8), .REFRACT(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy3),
        .sorted_in(sorted_in), .threshold(threshold), .leak(leak),
        .spike_out(spk3), .potential(pot3), .count_out(cnt3),
        .therm_err(err3), .spike_count(sc3));

    spike_integrate_fire #(.N(16), .ACC_W(8), .REFRACT(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
        .sorted_in(sorted_in), .threshold(threshold), .leak(leak),
        .spike_out(spk0), .potential(pot0), .count_out(cnt0),
        .therm_err(err0), .spike_count(sc0));

    task automatic model_reset();
        m_pot = 0; m_refr = 0; m_cnt = 0; m_sc = 0; m_err = 1'b0; m_spk = 1'b0;
    endtask

    // Drive one cycle, advance the model by the same cycle, return at posedge+1.
    task automatic step(input logic v, input logic [15:0] s, input int r);
        int          c;
        int          nx;
        logic [15:0] th;
        in_valid  = v;
        sorted_in = s;
        m_spk     = 1'b0;
        if (v && m_refr == 0) begin
            c  = $countones(s);
            th = (c == 0) ? 16'h0000 : (16'hFFFF << (16 - c));
            m_cnt = c;
            m_err = (s != th);
            nx = m_pot + c - int'(leak);
            if (nx < 0)   nx = 0;
            if (nx > 255) nx = 255;
            if (nx >= int'(threshold)) begin
                m_pot  = 0;
                m_spk  = 1'b1;
                m_sc   = (m_sc + 1) % 65536;
                m_refr = r;
            end else begin
                m_pot = nx;
            end
        end else if (m_refr > 0) begin
            m_refr = m_refr - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0; sorted_in = 16'h0000;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        in_valid = 1'b0; sorted_in = 16'h0000; threshold = 8'd10; leak = 8'd0;
        reset = 1'b1;
        #3;
        total_cnt++; if (rdy2 !== 1'b1) $display("FAIL reset_ready: got %b want 1", rdy2); else pass_cnt++;
        total_cnt++; if ({spk2, err2, pot2, cnt2, sc2} !== 31'd0)
            $display("FAIL reset_outputs: got spk=%b err=%b pot=%0d cnt=%0d sc=%0d want all 0", spk2, err2, pot2, cnt2, sc2);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset_mid_refract();
        apply_reset();
        threshold = 8'd0; leak = 8'd0;
        step(1'b1, 16'hF000, 3);
        total_cnt++; if (spk3 !== 1'b1 || rdy3 !== 1'b0)
            $display("FAIL mid_refr_fire: got spk=%b rdy=%b want spk=1 rdy=0", spk3, rdy3);
        else pass_cnt++;
        reset = 1'b1;
        #2;
        total_cnt++; if ({spk3, err3, pot3, cnt3, sc3} !== 31'd0 || rdy3 !== 1'b1)
            $display("FAIL mid_refr_reset: got spk=%b err=%b pot=%0d cnt=%0d sc=%0d rdy=%b want zeros rdy=1",
                     spk3, err3, pot3, cnt3, sc3, rdy3);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        threshold = 8'd100;
        step(1'b1, 16'hFF00, 3);
        total_cnt++; if (pot3 !== 8'(m_pot) || cnt3 !== 5'(m_cnt) || rdy3 !== 1'b1)
            $display("FAIL mid_refr_after: got pot=%0d cnt=%0d rdy=%b want pot=%0d cnt=%0d rdy=1", pot3, cnt3, rdy3, m_pot, m_cnt);
        else pass_cnt++;
    endtask

    task automatic test_threshold_fire();
        apply_reset();
        threshold = 8'd20; leak = 8'd0;
        step(1'b1, 16'hFF00, 2);
        total_cnt++; if (pot2 !== 8'(m_pot) || spk2 !== 1'b0)
            $display("FAIL thr_first: got pot=%0d spk=%b want pot=%0d spk=0", pot2, spk2, m_pot);
        else pass_cnt++;
        step(1'b1, 16'hFFF0, 2);
        total_cnt++; if (pot2 !== 8'd0 || spk2 !== 1'b1 || sc2 !== 16'(m_sc))
            $display("FAIL thr_fire: got pot=%0d spk=%b sc=%0d want pot=0 spk=1 sc=%0d", pot2, spk2, sc2, m_sc);
        else pass_cnt++;
        step(1'b1, 16'hFFF0, 2);
        total_cnt++; if (spk2 !== 1'b0)
            $display("FAIL thr_one_cycle: got spk=%b want 0", spk2);
        else pass_cnt++;
    endtask

    task automatic test_refract_handshake();
        apply_reset();
        threshold = 8'd4; leak = 8'd0;
        step(1'b1, 16'hF000, 2);
        total_cnt++; if (spk2 !== 1'b1 || rdy2 !== 1'b0)
            $display("FAIL refr_fire: got spk=%b rdy=%b want spk=1 rdy=0", spk2, rdy2);
        else pass_cnt++;
        step(1'b1, 16'hFF00, 2);
        total_cnt++; if (rdy2 !== 1'b0 || cnt2 !== 5'(m_cnt) || pot2 !== 8'd0 || spk2 !== 1'b0)
            $display("FAIL refr_hold1: got rdy=%b cnt=%0d pot=%0d spk=%b want rdy=0 cnt=%0d pot=0 spk=0", rdy2, cnt2, pot2, spk2, m_cnt);
        else pass_cnt++;
        step(1'b1, 16'hFF00, 2);
        total_cnt++; if (rdy2 !== 1'b1 || cnt2 !== 5'd4)
            $display("FAIL refr_hold2: got rdy=%b cnt=%0d want rdy=1 cnt=4", rdy2, cnt2);
        else pass_cnt++;
        step(1'b1, 16'hFF00, 2);
        total_cnt++; if (cnt2 !== 5'(m_cnt) || spk2 !== m_spk)
            $display("FAIL refr_accept: got cnt=%0d spk=%b want cnt=%0d spk=%b", cnt2, spk2, m_cnt, m_spk);
        else pass_cnt++;
    endtask

    task automatic test_leak_and_saturation();
        apply_reset();
        threshold = 8'd255; leak = 8'd0;
        step(1'b1, 16'hC000, 2);
        leak = 8'd5;
        step(1'b1, 16'h0000, 2);
        total_cnt++; if (pot2 !== 8'd0)
            $display("FAIL leak_floor: got pot=%0d want 0", pot2);
        else pass_cnt++;
        leak = 8'd0;
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 16'hFFFF, 2);
            total_cnt++; if (pot2 !== 8'(m_pot) || spk2 !== m_spk)
                $display("FAIL saturate_%0d: got pot=%0d spk=%b want pot=%0d spk=%b", i, pot2, spk2, m_pot, m_spk);
            else pass_cnt++;
        end
        total_cnt++; if (sc2 !== 16'd1)
            $display("FAIL saturate_count: got sc=%0d want 1", sc2);
        else pass_cnt++;
    endtask

    task automatic test_bubble();
        apply_reset();
        threshold = 8'd255; leak = 8'd0;
        step(1'b1, 16'hF0F0, 2);
        total_cnt++; if (cnt2 !== 5'd8 || err2 !== 1'b1)
            $display("FAIL bubble_set: got cnt=%0d err=%b want cnt=8 err=1", cnt2, err2);
        else pass_cnt++;
        step(1'b0, 16'h0000, 2);
        total_cnt++; if (err2 !== 1'b1 || cnt2 !== 5'd8)
            $display("FAIL bubble_hold: got cnt=%0d err=%b want cnt=8 err=1", cnt2, err2);
        else pass_cnt++;
        step(1'b1, 16'hC000, 2);
        total_cnt++; if (cnt2 !== 5'd2 || err2 !== 1'b0)
            $display("FAIL bubble_clear: got cnt=%0d err=%b want cnt=2 err=0", cnt2, err2);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int          c;
        logic [15:0] s;
        logic        v;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            threshold = 8'($urandom_range(0, 60));
            leak      = 8'($urandom_range(0, 6));
            v         = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                c = $urandom_range(0, 16);
                s = (c == 0) ? 16'h0000 : (16'hFFFF << (16 - c));
            end else begin
                s = 16'($urandom);
            end
            step(v, s, 2);
            total_cnt++; if (rdy2 !== (m_refr == 0))
                $display("FAIL rand_ready_%0d: got %b want %b", i, rdy2, (m_refr == 0));
            else pass_cnt++;
            total_cnt++; if (pot2 !== 8'(m_pot))
                $display("FAIL rand_pot_%0d: got %0d want %0d", i, pot2, m_pot);
            else pass_cnt++;
            total_cnt++; if (spk2 !== m_spk || sc2 !== 16'(m_sc))
                $display("FAIL rand_spike_%0d: got spk=%b sc=%0d want spk=%b sc=%0d", i, spk2, sc2, m_spk, m_sc);
            else pass_cnt++;
            total_cnt++; if (cnt2 !== 5'(m_cnt) || err2 !== m_err)
                $display("FAIL rand_count_%0d: got cnt=%0d err=%b want cnt=%0d err=%b", i, cnt2, err2, m_cnt, m_err);
            else pass_cnt++;
        end
    endtask

    task automatic test_threshold0_wrap();
        int bad = 0;
        apply_reset();
        threshold = 8'd0; leak = 8'd0;
        for (int i = 0; i < 65535; i++) begin
            step(1'b1, (i % 3 == 0) ? 16'h0000 : 16'($urandom), 0);
            if (spk0 !== 1'b1 || rdy0 !== 1'b1) bad++;
        end
        total_cnt++; if (bad != 0)
            $display("FAIL thr0_every_cycle: got %0d bad cycles want 0", bad);
        else pass_cnt++;
        total_cnt++; if (sc0 !== 16'hFFFF || sc0 !== 16'(m_sc))
            $display("FAIL thr0_count_max: got %h want ffff", sc0);
        else pass_cnt++;
        step(1'b1, 16'h0000, 0);
        total_cnt++; if (sc0 !== 16'h0000 || spk0 !== 1'b1 || pot0 !== 8'd0)
            $display("FAIL thr0_wrap: got sc=%h spk=%b pot=%0d want sc=0000 spk=1 pot=0", sc0, spk0, pot0);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; sorted_in = 16'h0000; threshold = 8'd0; leak = 8'd0;
        model_reset();
        test_reset();
        test_reset_mid_refract();
        test_threshold_fire();
        test_refract_handshake();
        test_leak_and_saturation();
        test_bubble();
        test_random();
        test_threshold0_wrap();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
